// File: rtl/pll_pkg.sv
// Shared definitions for the digital PLL blocks: pending-counter width,
// ID phase encoding and the saturating signed accumulator helper.
package pll_pkg;

  localparam int PEND_WIDTH = 4;

  // Two-bit ID phase; bit 1 is the ID output level.
  typedef enum logic [1:0] {
    PH_LOW0  = 2'd0,
    PH_LOW1  = 2'd1,
    PH_HIGH0 = 2'd2,
    PH_HIGH1 = 2'd3
  } phase_e;

  // Add a small signed delta to a signed counter, clamping to +/-limit.
  function automatic logic signed [PEND_WIDTH-1:0] sat_add(
    input logic signed [PEND_WIDTH-1:0] value,
    input int                           delta,
    input int                           limit
  );
    int sum;
    sum = int'(value) + delta;
    if (sum > limit) begin
      sum = limit;
    end else if (sum < -limit) begin
      sum = -limit;
    end
    return PEND_WIDTH'(sum);
  endfunction

endpackage

// File: rtl/id_counter_divide_by_n.sv
// DivideByN: counts rising edges of the corrected ID wave and produces the
// phase-detector feedback wave. The ratio is latched at reset and at each
// wrap so a new divider value never truncates a divide cycle in flight.
module divide_by_n #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 rise_i,
  input  logic [DIV_WIDTH-1:0] divider_i,
  output logic                 div_out_o
);

  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] count_next;
  logic [DIV_WIDTH-1:0] nlat;
  logic [DIV_WIDTH-1:0] nlat_next;

  // Ratios below 2 cannot produce a two-level wave, so they run as 2.
  function automatic logic [DIV_WIDTH-1:0] norm_ratio(input logic [DIV_WIDTH-1:0] ratio);
    return (ratio < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : ratio;
  endfunction

  // Next count and ratio on each ID rising edge; wrap reloads the ratio.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    count_next = count;
    nlat_next  = nlat;
    if (rise_i) begin
      if (count == nlat - DIV_WIDTH'(1)) begin
        count_next = '0;
        nlat_next  = norm_ratio(divider_i);
      end else begin
        count_next = count + DIV_WIDTH'(1);
      end
    end
  end

  // Register count, latched ratio and the output level derived from them.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count     <= '0;
      nlat      <= norm_ratio(divider_i);
      div_out_o <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      count     <= count_next;
      nlat      <= nlat_next;
      div_out_o <= (count_next >= (nlat_next >> 1));
    end
  end

endmodule

// File: rtl/id_counter.sv
// Increment/decrement counter: turns the ID tick stream into a nominal /4
// wave, shortens or stretches one period per pending loop-filter correction,
// and feeds the corrected wave through DivideByN to the phase detector.
module id_counter
  import pll_pkg::*;
#(
  parameter int DIV_WIDTH = 8,
  parameter int PEND_MAX  = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  idClkEn_i,
  input  logic                  carry_i,
  input  logic                  borrow_i,
  input  logic [DIV_WIDTH-1:0]  divider_i,
  output logic                  idOut_o,
  output logic                  divOut_o,
  output logic                  adjusted_o,
  output logic [PEND_WIDTH-1:0] pending_o
);

  phase_e                       phase;
  phase_e                       phase_next;
  logic                         serviced;
  logic signed [PEND_WIDTH-1:0] pending;
  logic                         do_advance;
  logic                         do_retard;
  logic                         rise;
  int                           pend_delta;

  // Service decision at phase 1 and the resulting next phase and pending delta.
  always_comb begin
    phase_next = phase;
    do_advance = 1'b0;
    do_retard  = 1'b0;
    if (idClkEn_i) begin
      if (phase == PH_LOW1 && !serviced && pending > 0) begin
        do_advance = 1'b1;
        phase_next = PH_HIGH1;
      end else if (phase == PH_LOW1 && !serviced && pending < 0) begin
        do_retard  = 1'b1;
        phase_next = PH_LOW1;
      end else begin
        phase_next = phase_e'(phase + 2'd1);
      end
    end
    // An advance consumes a positive correction, a retard a negative one.
    pend_delta = int'(carry_i) - int'(borrow_i)
               - (do_advance ? 1 : 0) + (do_retard ? 1 : 0);
    rise = idClkEn_i && !phase[1] && phase_next[1];
  end

  // Phase FSM, one-correction-per-period flag, pending counter and strobe.
  always_ff @(posedge clk_i) begin
    // NOTE: reset is synchronous and covers every register; there is no
    // memory here, so nothing is left to power-up state.
    if (reset_i) begin
      phase      <= PH_LOW0;
      serviced   <= 1'b0;
      pending    <= '0;
      adjusted_o <= 1'b0;
    end else begin
      phase <= phase_next;
      if (idClkEn_i && phase == PH_HIGH1) begin
        serviced <= 1'b0;
      end else if (do_advance || do_retard) begin
        serviced <= 1'b1;
      end
      pending    <= sat_add(pending, pend_delta, PEND_MAX);
      adjusted_o <= do_advance || do_retard;
    end
  end

  assign idOut_o   = phase[1];
  assign pending_o = pending;

  divide_by_n #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_divide_by_n (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .rise_i    (rise),
    .divider_i (divider_i),
    .div_out_o (divOut_o)
  );

endmodule

// File: tb/tb_id_counter.sv
// Scoreboard bench for id_counter: stimulus drives on the falling edge and
// pushes the reference model's expected outputs; a monitor pops and compares
// one entry shortly after every rising edge.
module tb_id_counter;

  localparam int DW = 8;
  localparam int PM = 3;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          tick = 1'b0;
  logic          carry = 1'b0;
  logic          borrow = 1'b0;
  logic [DW-1:0] divider = 8'd5;
  logic          id_out;
  logic          div_out;
  logic          adjusted;
  logic [3:0]    pending;

  always #5 clk = ~clk;

  id_counter #(.DIV_WIDTH(DW), .PEND_MAX(PM)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .idClkEn_i  (tick),
    .carry_i    (carry),
    .borrow_i   (borrow),
    .divider_i  (divider),
    .idOut_o    (id_out),
    .divOut_o   (div_out),
    .adjusted_o (adjusted),
    .pending_o  (pending)
  );

  typedef struct {
    int id_out;
    int div_out;
    int adjusted;
    int pending;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position within the current period and the period kind
  // (0 normal 4 ticks, 1 short 3 ticks, 2 long 5 ticks).
  int m_pos, m_kind, m_pend, m_adj, m_rises, m_nlat, m_div;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int norm_n(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int low_len(input int kind);
    return (kind == 2) ? 3 : 2;
  endfunction

  function automatic int per_len(input int kind);
    return (kind == 1) ? 3 : ((kind == 2) ? 5 : 4);
  endfunction

  task automatic model_step(input bit r, input bit t, input bit c, input bit b, input int d);
    int  svc;
    bit  old_id;
    bit  new_id;
    if (r) begin
      m_pos = 0; m_kind = 0; m_pend = 0; m_adj = 0;
      m_rises = 0; m_nlat = norm_n(d); m_div = 0;
      return;
    end
    svc = 0;
    if (t) begin
      if (m_pos == 1 && m_kind == 0) begin
        if (m_pend > 0) begin
          m_kind = 1; svc = 1;
        end else if (m_pend < 0) begin
          m_kind = 2; svc = -1;
        end
      end
      old_id = (m_pos >= low_len(m_kind));
      m_pos++;
      if (m_pos == per_len(m_kind)) begin
        m_pos = 0; m_kind = 0;
      end
      new_id = (m_pos >= low_len(m_kind));
      if (!old_id && new_id) begin
        // Divider: rising edges counted modulo the ratio latched at wrap.
        m_rises++;
        if (m_rises == m_nlat) begin
          m_rises = 0;
          m_nlat  = norm_n(d);
        end
        m_div = (m_rises >= m_nlat / 2) ? 1 : 0;
      end
    end
    m_pend = m_pend + int'(c) - int'(b) - svc;
    if (m_pend > PM) m_pend = PM;
    if (m_pend < -PM) m_pend = -PM;
    m_adj = (svc != 0) ? 1 : 0;
  endtask

  task automatic drive(input bit r, input bit t, input bit c, input bit b, input int d);
    exp_t e;
    @(negedge clk);
    reset_i = r; tick = t; carry = c; borrow = b; divider = DW'(d);
    model_step(r, t, c, b, d);
    e.id_out   = (m_pos >= low_len(m_kind)) ? 1 : 0;
    e.div_out  = m_div;
    e.adjusted = m_adj;
    e.pending  = m_pend;
    sb_q.push_back(e);
  endtask

  task automatic ticks(input int n, input int d);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, d);
  endtask

  // Monitor: one expected entry per clock once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("id_out",   int'(id_out),   e.id_out);
        check("div_out",  int'(div_out),  e.div_out);
        check("adjusted", int'(adjusted), e.adjusted);
        check("pending",  int'($signed(pending)), e.pending);
      end
    end
  end

  initial begin
    int d;
    d = 5;
    drive(1'b1, 1'b0, 1'b0, 1'b0, d);
    drive(1'b1, 1'b0, 1'b0, 1'b0, d);
    ticks(24, d);                              // nominal 0,0,1,1
    drive(1'b0, 1'b0, 1'b1, 1'b0, d);          // single carry at phase 0
    ticks(12, d);
    drive(1'b0, 1'b0, 1'b0, 1'b1, d);          // single borrow
    ticks(12, d);
    drive(1'b0, 1'b1, 1'b1, 1'b1, d);          // carry and borrow cancel
    ticks(8, d);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, d);  // saturate
    ticks(24, d);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, d);  // negative saturation
    ticks(30, d);
    ticks(7, d);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3);          // reset mid-period, new ratio
    d = 3;
    ticks(30, d);
    d = 0;                                     // latched at next wrap as 2
    ticks(30, d);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) d = $urandom_range(0, 9);
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 11) == 0,
            d);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, d);
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_counter.md
# id_counter

Increment/decrement counter for the digital PLL: the consumer of the loop filter's carry/borrow pulses. It turns a clock-enable tick stream into a nominal ÷4 square wave and advances or retards its phase by one tick per pending carry or borrow. It then divides the corrected wave by a programmable N for the phase-detector feedback input. It sits between the loop filter and the phase detector, and closes the loop.

## Interface
Parameters:
- DIV_WIDTH, 8, width of the feedback divider value and its counter
- PEND_MAX, 3, saturation magnitude of the pending-correction counter (1..7)

Ports:
- clk_i  input  1  single system clock, rising edge
- reset_i  input  1  synchronous, active-high reset
- idClkEn_i  input  1  tick strobe; one high cycle equals one ID tick
- carry_i  input  1  one-cycle pulse from loop filter max trigger; requests a phase advance
- borrow_i  input  1  one-cycle pulse from loop filter min trigger; requests a phase retard
- divider_i  input  DIV_WIDTH  feedback divide ratio N
- idOut_o  output  1  corrected ID wave, registered
- divOut_o  output  1  idOut_o divided by N, registered
- adjusted_o  output  1  one-cycle strobe when a correction is applied
- pending_o  output  4  signed count of unserviced corrections (two's complement)

## Operation
- Phase register, 2 bits; idOut_o = phase[1]. Nominal behaviour: phase increments by 1 per tick, giving a period of 4 ticks (low on phase 0 and 1, high on phase 2 and 3).
- Service point: a tick at which phase == 1.
  - pending > 0: phase += 2 (01→11). The period shortens to 3 ticks (low 2, high 1).
  - pending < 0: phase holds at 01. The period lengthens to 5 ticks (low 3, high 2).
  - At most one correction per idOut_o period.
- pending update on every clk_i cycle, whether or not a tick occurs: next = pending + carry_i − borrow_i − svc.
  - svc = +1 for an applied advance, −1 for an applied retard, otherwise 0.
  - The result saturates to ±PEND_MAX.
  - carry_i and borrow_i asserted in the same cycle cancel each other.
- adjusted_o is high in the cycle after a service tick, for one cycle only.
- Divider:
  - divCount (DIV_WIDTH bits) increments on each idOut_o rising transition (a tick that moves phase into the high half).
  - It wraps to 0 after reaching Nlat−1.
  - Nlat latches divider_i at reset and at each wrap. Values 0 and 1 are treated as 2.
  - divOut_o = (divCount ≥ Nlat>>1), registered.
- Reset values: phase 0, idOut_o 0, divCount 0, Nlat = max(divider_i, 2), divOut_o 0, pending_o 0, adjusted_o 0.
- Reset takes priority over every other input. Reset mid-period discards pending corrections and the partial period.

## Timing
- A tick in cycle t updates phase, idOut_o, divCount and divOut_o at the clk_i edge ending cycle t. The new values are visible in cycle t+1.
- carry_i/borrow_i in cycle t → pending_o changes in cycle t+1. The earliest service is a tick in cycle t+1 or later with phase == 1.
- A carry in the same cycle as a retard service: both apply, and the net pending change is +2 toward zero/positive, then saturation.
- With no ticks, phase is frozen. Pending still accumulates.
- A divider_i change takes effect only after the current divide cycle wraps.

## Structure
- Shared package pll_pkg holds:
  - PEND_WIDTH = 4
  - phase constants PH_LOW0/PH_LOW1/PH_HIGH0/PH_HIGH1
  - a saturating signed-add function, shared with future loop-filter variants
- One sub-module, DivideByN: the edge-counting divider with ratio latch, parameterised by DIV_WIDTH. The top-level block holds the phase FSM and the pending counter.

## Test plan
- Reset, then idClkEn_i held high with no corrections → idOut_o pattern 0,0,1,1 repeating; pending_o = 0; adjusted_o never high.
- A single carry_i pulse while phase = 0 → next period is 0,0,1 (3 ticks); adjusted_o pulses once; pending_o returns 1→0.
- A single borrow_i pulse → next period is 0,0,0,1,1 (5 ticks); pending_o goes −1→0.
- carry_i and borrow_i high in the same cycle → pending_o stays 0 and the period stays 4.
- Five consecutive carry_i pulses with PEND_MAX = 3 → pending_o saturates at 3; the next three periods are 3 ticks each, then the period returns to 4.
- divider_i = 5 → divOut_o is low for 2 idOut_o periods and high for 3. Assert reset_i mid-cycle → all outputs at reset values in the next cycle, and divOut_o restarts low.
